// File: rtl/lm_seq_pkg.sv
// ---------------------------------------------------------------------------
// lm_seq_pkg
// Shared constants and the sequencer state type for the Load-Multiple
// write-back sequencer.
//   DATA_W      data / memory address width
//   REG_ADDR_W  register index width
//   MASK_W      register mask width (= 2**REG_ADDR_W)
//   PC_REG_IDX  index of the program counter register (R7)
//   lm_state_e  IDLE / REQ / WRITE / DONE
// ---------------------------------------------------------------------------
package lm_seq_pkg;

   localparam int DATA_W     = 16;
   localparam int REG_ADDR_W = 3;
   localparam int MASK_W     = 8;
   localparam int PC_REG_IDX = 7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } lm_state_e;

endpackage

// File: rtl/lowest_set_bit_enc.sv
// ---------------------------------------------------------------------------
// lowest_set_bit_enc
// Combinational priority encoder: index of the lowest set bit of a mask.
//   mask_i   in   MASK_W  mask to encode
//   idx_o    out  IDX_W   index of lowest set bit (0 when mask is empty)
//   valid_o  out  1       mask has at least one bit set
// ---------------------------------------------------------------------------
module lowest_set_bit_enc #(
   parameter int MASK_W = 8,
   parameter int IDX_W  = 3
) (
   input  logic [MASK_W-1:0] mask_i,
   output logic [IDX_W-1:0]  idx_o,
   output logic              valid_o
);

   always_comb begin
      idx_o   = '0;
      valid_o = |mask_i;
      // Scan downwards so the last hit (lowest index) wins.
      for (int i = MASK_W - 1; i >= 0; i--) begin
         if (mask_i[i]) begin
            idx_o = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/lm_wb_sequencer.sv
// ---------------------------------------------------------------------------
// lm_wb_sequencer
// Load-Multiple sequencer: one memory read per set bit of the register mask,
// each loaded word written to the register file through the shared
// write-back port. The pipeline write-back always has priority on that port.
//
// Ports
//   clk, reset              clock; synchronous active-high reset
//   start, mask, base_addr  LM issue; sampled only in IDLE
//   busy, done              pipeline stall / one-cycle completion pulse
//   mem_req, mem_addr       read request and address
//   mem_ack, mem_rdata      request accepted; data valid in the same cycle
//   wb_we_in/addr/data      pipeline write-back request
//   rf_we/waddr/wdata       register-file write port
//   flush                   R7 reloaded by this LM (optional feature)
//   state_o                 current FSM state, for observation
//
// Handshake: a read transfers in the cycle where mem_req && mem_ack; until
// then mem_addr holds steady. The register-file port is a plain
// write-enable: the sequencer only writes when wb_we_in is low.
//
// Optional feature: define LM_SEQ_PC_FLUSH_EN to raise flush in the DONE
// cycle when the sequence wrote R7. Without it flush is tied low.
// ---------------------------------------------------------------------------
module lm_wb_sequencer
   import lm_seq_pkg::*;
#(
   parameter int DATA_W_P     = DATA_W,
   parameter int REG_ADDR_W_P = REG_ADDR_W,
   parameter int MASK_W_P     = MASK_W
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [MASK_W_P-1:0]     mask,
   input  logic [DATA_W_P-1:0]     base_addr,
   output logic                    busy,
   output logic                    done,
   output logic                    mem_req,
   output logic [DATA_W_P-1:0]     mem_addr,
   input  logic                    mem_ack,
   input  logic [DATA_W_P-1:0]     mem_rdata,
   input  logic                    wb_we_in,
   input  logic [REG_ADDR_W_P-1:0] wb_addr_in,
   input  logic [DATA_W_P-1:0]     wb_data_in,
   output logic                    rf_we,
   output logic [REG_ADDR_W_P-1:0] rf_waddr,
   output logic [DATA_W_P-1:0]     rf_wdata,
   output logic                    flush,
   output lm_state_e               state_o
);

   lm_state_e             state_q, state_d;
   logic [MASK_W_P-1:0]   mask_q,  mask_d;
   logic [DATA_W_P-1:0]   addr_q,  addr_d;
   logic [DATA_W_P-1:0]   hold_q,  hold_d;

   logic [MASK_W_P-1:0]     enc_in;
   logic [REG_ADDR_W_P-1:0] lsb_idx;
   logic                    lsb_valid;
   logic [MASK_W_P-1:0]     mask_clr;

   // In IDLE the encoder looks at the incoming mask to decide whether there
   // is anything to load; afterwards it tracks the remaining mask. The
   // remaining mask does not change between the ack in REQ and the write,
   // so the encoder output in WRITE is the target register of the load.
   assign enc_in = (state_q == ST_IDLE) ? mask : mask_q;

   lowest_set_bit_enc #(
      .MASK_W (MASK_W_P),
      .IDX_W  (REG_ADDR_W_P)
   ) u_enc (
      .mask_i  (enc_in),
      .idx_o   (lsb_idx),
      .valid_o (lsb_valid)
   );

   assign mask_clr = mask_q & ~(MASK_W_P'(1) << lsb_idx);

`ifdef LM_SEQ_PC_FLUSH_EN
   logic flag_q, flag_d;
`endif

   always_comb begin
      state_d  = state_q;
      mask_d   = mask_q;
      addr_d   = addr_q;
      hold_d   = hold_q;
`ifdef LM_SEQ_PC_FLUSH_EN
      flag_d   = flag_q;
`endif
      mem_req  = 1'b0;
      mem_addr = '0;
      done     = 1'b0;
      rf_we    = wb_we_in;
      rf_waddr = wb_addr_in;
      rf_wdata = wb_data_in;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               mask_d  = mask;
               addr_d  = base_addr;
`ifdef LM_SEQ_PC_FLUSH_EN
               flag_d  = 1'b0;
`endif
               state_d = lsb_valid ? ST_REQ : ST_DONE;
            end
         end
         ST_REQ: begin
            mem_req  = 1'b1;
            mem_addr = addr_q;
            if (mem_ack) begin
               hold_d  = mem_rdata;
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            // Pipeline write-back owns the port; retry next cycle.
            if (!wb_we_in) begin
               rf_we    = 1'b1;
               rf_waddr = lsb_idx;
               rf_wdata = hold_q;
               mask_d   = mask_clr;
               addr_d   = addr_q + DATA_W_P'(1);
`ifdef LM_SEQ_PC_FLUSH_EN
               if (lsb_idx == REG_ADDR_W_P'(PC_REG_IDX)) begin
                  flag_d = 1'b1;
               end
`endif
               state_d  = (mask_clr == '0) ? ST_DONE : ST_REQ;
            end
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         mask_q  <= '0;
         addr_q  <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         addr_q  <= addr_d;
         hold_q  <= hold_d;
      end
   end

`ifdef LM_SEQ_PC_FLUSH_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         flag_q <= 1'b0;
      end else begin
         flag_q <= flag_d;
      end
   end
   assign flush = (state_q == ST_DONE) && flag_q;
`else
   assign flush = 1'b0;
`endif

   assign busy    = (state_q != ST_IDLE);
   assign state_o = state_q;

endmodule

// File: tb/tb_lm_wb_sequencer.sv
module tb_lm_wb_sequencer;
   import lm_seq_pkg::*;

   // ---------------- clock / reset / signals ----------------
   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  mask;
   logic [15:0] base_addr;
   logic        busy, done, mem_req, mem_ack;
   logic [15:0] mem_addr, mem_rdata;
   logic        wb_we_in;
   logic [2:0]  wb_addr_in;
   logic [15:0] wb_data_in;
   logic        rf_we;
   logic [2:0]  rf_waddr;
   logic [15:0] rf_wdata;
   logic        flush;
   lm_state_e   state_dbg;

   always #5 clk = ~clk;

   lm_wb_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .mask       (mask),
      .base_addr  (base_addr),
      .busy       (busy),
      .done       (done),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .wb_we_in   (wb_we_in),
      .wb_addr_in (wb_addr_in),
      .wb_data_in (wb_data_in),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .flush      (flush),
      .state_o    (state_dbg)
   );

   int total = 0;
   int bad   = 0;

   // ---------------- memory model ----------------
   function automatic logic [15:0] rd_model(input logic [15:0] a);
      return a ^ 16'h5A3C;
   endfunction

   int ack_delay = 0;
   int ack_cnt   = 0;
   assign mem_ack   = mem_req && (ack_cnt >= ack_delay);
   assign mem_rdata = rd_model(mem_addr);

   always @(posedge clk) begin
      if (reset || !mem_req || mem_ack) ack_cnt <= 0;
      else                              ack_cnt <= ack_cnt + 1;
   end

   // ---------------- monitor / scoreboard ----------------
   logic [18:0] obs_q[$];
   logic [18:0] exp_q[$];
   logic [15:0] req_addr_q[$];
   logic [15:0] exp_addr_q[$];
   int busy_cnt, done_cnt, req_cnt, flush_cnt, flush_stray;

   always @(negedge clk) begin
      if (rf_we) obs_q.push_back({rf_waddr, rf_wdata});
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (mem_req) begin
         req_cnt++;
         req_addr_q.push_back(mem_addr);
      end
      if (flush && done)  flush_cnt++;
      if (flush && !done) flush_stray++;
   end

   task automatic clear_mon();
      obs_q.delete();
      exp_q.delete();
      req_addr_q.delete();
      exp_addr_q.delete();
      busy_cnt = 0; done_cnt = 0; req_cnt = 0; flush_cnt = 0; flush_stray = 0;
   endtask

   // ---------------- driver ----------------
   task automatic run_lm(input logic [7:0] m, input logic [15:0] b,
                         input int wb_cyc, input int restart_cyc,
                         output int done_cyc);
      clear_mon();
      @(posedge clk); #1;
      start = 1'b1; mask = m; base_addr = b;
      done_cyc = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(posedge clk); #1;
         start      = 1'b0;
         wb_we_in   = (cyc == wb_cyc);
         wb_addr_in = 3'd3;
         wb_data_in = 16'hBEEF;
         if (cyc == restart_cyc) begin
            start = 1'b1; mask = 8'hFF; base_addr = 16'h0000;
         end
         @(negedge clk);
         if (done) begin
            done_cyc = cyc;
            break;
         end
      end
      #1;
      wb_we_in = 1'b0;
      total++;
      if (done_cyc == 0) begin
         bad++;
         $display("FAIL lm_timeout got=no_done exp=done within 40 cycles (mask=%h)", m);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1; start = 1'b0; mask = 8'h00; base_addr = 16'h0000;
      wb_we_in = 1'b1; wb_addr_in = 3'd5; wb_data_in = 16'h1234;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (done !== 1'b0)     begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
      total++; if (mem_req !== 1'b0)  begin bad++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
      total++; if (mem_addr !== 16'h0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0000", mem_addr); end
      total++; if (flush !== 1'b0)    begin bad++; $display("FAIL reset_flush got=%b exp=0", flush); end
      total++; if (state_dbg !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
      total++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'd5, 16'h1234})
         begin bad++; $display("FAIL reset_passthru got=%b/%0d/%h exp=1/5/1234", rf_we, rf_waddr, rf_wdata); end
      @(posedge clk); #1;
      reset = 1'b0; wb_we_in = 1'b0;
   endtask

   task automatic test_basic();
      int dc;
      run_lm(8'h05, 16'h0040, 0, 0, dc);
      exp_q.push_back({3'd0, rd_model(16'h0040)});
      exp_q.push_back({3'd2, rd_model(16'h0041)});
      exp_addr_q.push_back(16'h0040);
      exp_addr_q.push_back(16'h0041);
      total++; if (dc !== 5)       begin bad++; $display("FAIL basic_done_cyc got=%0d exp=5", dc); end
      total++; if (busy_cnt !== 5) begin bad++; $display("FAIL basic_busy_cnt got=%0d exp=5", busy_cnt); end
      total++; if (done_cnt !== 1) begin bad++; $display("FAIL basic_done_cnt got=%0d exp=1", done_cnt); end
      total++; if (req_addr_q.size() !== exp_addr_q.size())
         begin bad++; $display("FAIL basic_req_n got=%0d exp=%0d", req_addr_q.size(), exp_addr_q.size()); end
      for (int i = 0; i < exp_addr_q.size() && i < req_addr_q.size(); i++) begin
         total++; if (req_addr_q[i] !== exp_addr_q[i])
            begin bad++; $display("FAIL basic_req_addr[%0d] got=%h exp=%h", i, req_addr_q[i], exp_addr_q[i]); end
      end
      total++; if (obs_q.size() !== exp_q.size())
         begin bad++; $display("FAIL basic_wr_n got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         total++; if (obs_q[i] !== exp_q[i])
            begin bad++; $display("FAIL basic_wr[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_mask_zero();
      int dc;
      run_lm(8'h00, 16'h1000, 0, 0, dc);
      total++; if (dc !== 1)           begin bad++; $display("FAIL zero_done_cyc got=%0d exp=1", dc); end
      total++; if (req_cnt !== 0)      begin bad++; $display("FAIL zero_req_cnt got=%0d exp=0", req_cnt); end
      total++; if (busy_cnt !== 1)     begin bad++; $display("FAIL zero_busy_cnt got=%0d exp=1", busy_cnt); end
      total++; if (done_cnt !== 1)     begin bad++; $display("FAIL zero_done_cnt got=%0d exp=1", done_cnt); end
      total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL zero_wr_n got=%0d exp=0", obs_q.size()); end
   endtask

   task automatic test_contention();
      int dc;
      run_lm(8'h08, 16'h0200, 2, 0, dc);
      exp_q.push_back({3'd3, 16'hBEEF});
      exp_q.push_back({3'd3, rd_model(16'h0200)});
      total++; if (dc !== 4) begin bad++; $display("FAIL cont_done_cyc got=%0d exp=4", dc); end
      total++; if (obs_q.size() !== exp_q.size())
         begin bad++; $display("FAIL cont_wr_n got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         total++; if (obs_q[i] !== exp_q[i])
            begin bad++; $display("FAIL cont_wr[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_wrap_delayed_ack();
      int dc;
      ack_delay = 2;
      run_lm(8'h03, 16'hFFFF, 0, 0, dc);
      ack_delay = 0;
      repeat (3) exp_addr_q.push_back(16'hFFFF);
      repeat (3) exp_addr_q.push_back(16'h0000);
      exp_q.push_back({3'd0, rd_model(16'hFFFF)});
      exp_q.push_back({3'd1, rd_model(16'h0000)});
      total++; if (dc !== 9) begin bad++; $display("FAIL wrap_done_cyc got=%0d exp=9", dc); end
      total++; if (req_addr_q.size() !== exp_addr_q.size())
         begin bad++; $display("FAIL wrap_req_n got=%0d exp=%0d", req_addr_q.size(), exp_addr_q.size()); end
      for (int i = 0; i < exp_addr_q.size() && i < req_addr_q.size(); i++) begin
         total++; if (req_addr_q[i] !== exp_addr_q[i])
            begin bad++; $display("FAIL wrap_req_addr[%0d] got=%h exp=%h", i, req_addr_q[i], exp_addr_q[i]); end
      end
      total++; if (obs_q.size() !== exp_q.size())
         begin bad++; $display("FAIL wrap_wr_n got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         total++; if (obs_q[i] !== exp_q[i])
            begin bad++; $display("FAIL wrap_wr[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_reset_mid();
      clear_mon();
      @(posedge clk); #1;
      start = 1'b1; mask = 8'hFF; base_addr = 16'h0010;
      for (int cyc = 1; cyc <= 3; cyc++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (cyc == 3) reset = 1'b1;
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      total++; if (state_dbg !== ST_IDLE) begin bad++; $display("FAIL rmid_state got=%0d exp=0", state_dbg); end
      total++; if (busy !== 1'b0)    begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rmid_mem_req got=%b exp=0", mem_req); end
      total++; if (mem_addr !== 16'h0) begin bad++; $display("FAIL rmid_mem_addr got=%h exp=0000", mem_addr); end
      repeat (4) @(posedge clk);
      #1;
      total++; if (obs_q.size() !== 1) begin bad++; $display("FAIL rmid_wr_n got=%0d exp=1", obs_q.size()); end
      if (obs_q.size() >= 1) begin
         total++; if (obs_q[0] !== {3'd0, rd_model(16'h0010)})
            begin bad++; $display("FAIL rmid_wr0 got=%h exp=%h", obs_q[0], {3'd0, rd_model(16'h0010)}); end
      end
      total++; if (req_cnt !== 2)  begin bad++; $display("FAIL rmid_req_cnt got=%0d exp=2", req_cnt); end
      total++; if (done_cnt !== 0) begin bad++; $display("FAIL rmid_done_cnt got=%0d exp=0", done_cnt); end
   endtask

   task automatic test_back_to_back();
      int dc;
      // Second start while busy must be ignored.
      run_lm(8'hA6, 16'h1234, 0, 2, dc);
      exp_q.push_back({3'd1, rd_model(16'h1234)});
      exp_q.push_back({3'd2, rd_model(16'h1235)});
      exp_q.push_back({3'd5, rd_model(16'h1236)});
      exp_q.push_back({3'd7, rd_model(16'h1237)});
      total++; if (dc !== 9) begin bad++; $display("FAIL b2b_a_done_cyc got=%0d exp=9", dc); end
      total++; if (obs_q.size() !== exp_q.size())
         begin bad++; $display("FAIL b2b_a_wr_n got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         total++; if (obs_q[i] !== exp_q[i])
            begin bad++; $display("FAIL b2b_a_wr[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
      end
      run_lm(8'h01, 16'h7FFF, 0, 0, dc);
      exp_q.push_back({3'd0, rd_model(16'h7FFF)});
      total++; if (dc !== 3) begin bad++; $display("FAIL b2b_b_done_cyc got=%0d exp=3", dc); end
      total++; if (obs_q.size() !== 1) begin bad++; $display("FAIL b2b_b_wr_n got=%0d exp=1", obs_q.size()); end
      if (obs_q.size() >= 1) begin
         total++; if (obs_q[0] !== exp_q[0])
            begin bad++; $display("FAIL b2b_b_wr0 got=%h exp=%h", obs_q[0], exp_q[0]); end
      end
   endtask

   task automatic test_flush();
      int dc;
      int exp_flush;
`ifdef LM_SEQ_PC_FLUSH_EN
      exp_flush = 1;
`else
      exp_flush = 0;
`endif
      run_lm(8'h80, 16'h0300, 0, 0, dc);
      total++; if (dc !== 3) begin bad++; $display("FAIL flush_done_cyc got=%0d exp=3", dc); end
      total++; if (flush_cnt !== exp_flush)
         begin bad++; $display("FAIL flush_with_done got=%0d exp=%0d", flush_cnt, exp_flush); end
      total++; if (flush_stray !== 0) begin bad++; $display("FAIL flush_stray got=%0d exp=0", flush_stray); end
      total++; if (obs_q.size() !== 1) begin bad++; $display("FAIL flush_wr_n got=%0d exp=1", obs_q.size()); end
      if (obs_q.size() >= 1) begin
         total++; if (obs_q[0] !== {3'd7, rd_model(16'h0300)})
            begin bad++; $display("FAIL flush_wr0 got=%h exp=%h", obs_q[0], {3'd7, rd_model(16'h0300)}); end
      end
      // Mask without R7 must never flush.
      run_lm(8'h05, 16'h0400, 0, 0, dc);
      total++; if (flush_cnt + flush_stray !== 0)
         begin bad++; $display("FAIL flush_no_r7 got=%0d exp=0", flush_cnt + flush_stray); end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_basic();
      test_mask_zero();
      test_contention();
      test_wrap_delayed_ack();
      test_reset_mid();
      test_back_to_back();
      test_flush();
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
